// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry.
//
// Holds up to two instructions (main + skid) between two pipeline stages with a
// valid/ready handshake on each side. With SKID=1, in_ready is decoded from the
// stage state alone, so upstream never sees a combinational path from out_ready.
// With SKID=0 the stage is a single entry whose in_ready follows out_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         upstream handshake
//   in_data, in_dest, in_cword  incoming packed data fields, dest index, control word
//   flush                       synchronous squash of all held entries
//   out_valid / out_ready       downstream handshake
//   out_data, out_dest, out_cword  main entry contents (cword reads 0 when not valid)
//   occupancy                   number of valid entries (0..2)
//   stall_count, stall_clr      saturating downstream-stall counter and its clear
`timescale 1ns/1ps
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_DATA  = 6,
  parameter int unsigned DEST_W  = 3,
  parameter int unsigned CWORD_W = 31,
  parameter int unsigned SKID    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0]        in_dest,
  input  logic [CWORD_W-1:0]       in_cword,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [DEST_W-1:0]        out_dest,
  output logic [CWORD_W-1:0]       out_cword,
  output logic [1:0]               occupancy,
  output logic [15:0]              stall_count,
  input  logic                     stall_clr
);

  localparam int unsigned DW = N_DATA * DATA_W;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]      main_data_q, skid_data_q;
  logic [DEST_W-1:0]  main_dest_q, skid_dest_q;
  logic [CWORD_W-1:0] main_cword_q, skid_cword_q;
  logic [15:0]        stall_count_q;

  logic accept, deliver;
  logic load_main, load_skid, main_from_skid;

  assign out_valid   = (state_q != StEmpty);
  assign occupancy   = state_q;
  assign out_data    = main_data_q;
  assign out_dest    = main_dest_q;
  assign out_cword   = out_valid ? main_cword_q : '0;
  assign stall_count = stall_count_q;

  // rst_n gates in_ready so upstream sees no acceptance while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = rst_n & (state_q != StFull);
    end else begin
      in_ready = rst_n & (~out_valid | out_ready);
    end
  end

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Deliver still completes downstream; any same-cycle accept is dropped.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StHalf;
            load_main = 1'b1;
          end
        end
        StHalf: begin
          if (accept && deliver) begin
            load_main = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (deliver) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (deliver) begin
            state_d        = StHalf;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_dest_q  <= '0;
      main_cword_q <= '0;
      skid_data_q  <= '0;
      skid_dest_q  <= '0;
      skid_cword_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_data_q  <= in_data;
        main_dest_q  <= in_dest;
        main_cword_q <= in_cword;
      end else if (main_from_skid) begin
        main_data_q  <= skid_data_q;
        main_dest_q  <= skid_dest_q;
        main_cword_q <= skid_cword_q;
      end
      if (load_skid) begin
        skid_data_q  <= in_data;
        skid_dest_q  <= in_dest;
        skid_cword_q <= in_cword;
      end
    end
  end

  // Clear wins over a same-cycle stall; flush does not touch the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall_clr) begin
      stall_count_q <= '0;
    end else if (out_valid && !out_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, streaming,
// randomized traffic against a queue model, async reset, stall saturation, and a
// SKID=0 instance for the combinational-ready case.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int DW = 96;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic          in_valid, in_ready, flush, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    in_dest, out_dest;
  logic [30:0]   in_cword, out_cword;
  logic [1:0]    occupancy;
  logic [15:0]   stall_count;

  // SKID=0 instance signals
  logic          iv0, ir0, ov0, or0;
  logic [DW-1:0] d0, od0;
  logic [2:0]    dst0, odst0;
  logic [30:0]   cw0, ocw0;
  logic [1:0]    occ0;
  logic [15:0]   st0;

  pipe_stage_reg #(.SKID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_cword(in_cword), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_cword(out_cword), .occupancy(occupancy),
    .stall_count(stall_count), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .in_data(d0), .in_dest(dst0), .in_cword(cw0), .flush(1'b0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_dest(odst0), .out_cword(ocw0), .occupancy(occ0),
    .stall_count(st0), .stall_clr(1'b0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] cw_of(input logic [15:0] f);
    return {f[14:0], f};
  endfunction

  task automatic drive(input logic v, input logic [15:0] f);
    in_valid = v;
    in_data  = {6{f}};
    in_dest  = f[2:0];
    in_cword = cw_of(f);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        iv, orr, fl;
    logic [15:0] din;
    logic [1:0]  occ;
    logic        ov, ir;
    logic [15:0] f0;
    logic [15:0] st;
    logic        chk_f0;
  } vec_t;
  vec_t tbl[12];

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    dest;
    logic [30:0]   cw;
  } ent_t;
  ent_t q[$];
  ent_t e;
  logic [15:0] s_m;
  logic acc, del;

  initial begin
    // Stall fill, drain, accept+deliver, flush in FULL with accept attempt, lone push.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'hA000, 2'd1, 1'b1, 1'b1, 16'hA000, 16'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'hB000, 2'd2, 1'b1, 1'b0, 16'hA000, 16'd1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'hC000, 2'd2, 1'b1, 1'b0, 16'hA000, 16'd2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'hA000, 16'd3, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1, 1'b1, 16'hB000, 16'd3, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 16'hB000, 16'd3, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h1111, 2'd1, 1'b1, 1'b1, 16'h1111, 16'd3, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b1, 16'h2222, 16'd3, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h3333, 2'd2, 1'b1, 1'b0, 16'h2222, 16'd4, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h4444, 2'd0, 1'b0, 1'b1, 16'h0000, 16'd4, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h1234, 2'd1, 1'b1, 1'b1, 16'h1234, 16'd4, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 16'h1234, 16'd4, 1'b1};

    rst_n = 1'b0; flush = 0; out_ready = 0; stall_clr = 0;
    drive(1'b0, 16'h0);
    iv0 = 0; or0 = 0; d0 = '0; dst0 = '0; cw0 = '0;

    // Reset state, checked with no clock edge dependence.
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_stall", stall_count, 0);
    #21;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].din);
      out_ready = tbl[i].orr;
      flush     = tbl[i].fl;
      tick();
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_ir", i), in_ready, tbl[i].ir);
      chk($sformatf("tbl%0d_cw", i), out_cword, tbl[i].ov ? cw_of(tbl[i].f0) : 31'd0);
      chk($sformatf("tbl%0d_stall", i), stall_count, tbl[i].st);
      if (tbl[i].chk_f0) begin
        chk($sformatf("tbl%0d_data", i), out_data, {6{tbl[i].f0}});
        chk($sformatf("tbl%0d_dest", i), out_dest, tbl[i].f0[2:0]);
      end
    end
    flush = 0;

    // Streaming at full rate, one-cycle latency.
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i));
      tick();
      chk("stream_data", out_data[15:0], 16'(i));
      chk("stream_occ", occupancy, 1);
      chk("stream_ov", out_valid, 1);
    end
    drive(1'b0, 16'h0);
    tick();
    chk("stream_drain", out_valid, 0);

    // Randomized traffic against an in-order queue of capacity two.
    do_reset();
    q.delete();
    s_m = 16'd0;
    repeat (3000) begin
      chk("rnd_ov", out_valid, q.size() != 0);
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_ir", in_ready, q.size() < 2);
      chk("rnd_cw", out_cword, (q.size() != 0) ? q[0].cw : 31'd0);
      chk("rnd_stall", stall_count, s_m);
      if (q.size() != 0) begin
        chk("rnd_data", out_data, q[0].d);
        chk("rnd_dest", out_dest, q[0].dest);
      end
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      stall_clr = ($urandom_range(0, 39) == 0);
      e.d    = {$urandom, $urandom, $urandom};
      e.dest = 3'($urandom);
      e.cw   = 31'($urandom);
      in_data = e.d; in_dest = e.dest; in_cword = e.cw;
      acc = in_valid && (q.size() < 2);
      del = (q.size() != 0) && out_ready;
      if (stall_clr) s_m = 16'd0;
      else if ((q.size() != 0) && !out_ready && s_m != 16'hFFFF) s_m = s_m + 16'd1;
      if (flush) q.delete();
      else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      tick();
    end
    flush = 0; stall_clr = 0; out_ready = 0;
    drive(1'b0, 16'h0);

    // Async reset mid-cycle while FULL.
    do_reset();
    drive(1'b1, 16'hA5A5);
    tick();
    drive(1'b1, 16'h5A5A);
    tick();
    drive(1'b0, 16'h0);
    chk("ar_full", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_ir", in_ready, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_cw", out_cword, 0);
    chk("ar_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_ir_after", in_ready, 1);
    tick();
    chk("ar_no_output", out_valid, 0);

    // Stall saturation and clear-wins.
    drive(1'b1, 16'h0BAD);
    out_ready = 0;
    tick();
    drive(1'b0, 16'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_count", stall_count, 16'hFFFF);
    chk("sat_hold_data", out_data[15:0], 16'h0BAD);
    stall_clr = 1;
    tick();
    chk("sat_clr", stall_count, 16'h0000);
    stall_clr = 0;
    tick();
    chk("sat_resume", stall_count, 16'h0001);

    // SKID=0: combinational ready, accept+deliver keeps one entry.
    iv0 = 1; d0 = {6{16'h1111}}; dst0 = 3'd1; cw0 = cw_of(16'h1111); or0 = 0;
    #1;
    chk("s0_ir_empty", ir0, 1);
    tick();
    chk("s0_ov", ov0, 1);
    chk("s0_first", od0[15:0], 16'h1111);
    d0 = {6{16'h5555}}; dst0 = 3'd5; cw0 = cw_of(16'h5555);
    #1;
    chk("s0_ir_blocked", ir0, 0);
    or0 = 1;
    #1;
    chk("s0_ir_comb", ir0, 1);
    tick();
    chk("s0_data", od0, {6{16'h5555}});
    chk("s0_occ", occ0, 1);
    chk("s0_ov2", ov0, 1);
    iv0 = 0;
    tick();
    chk("s0_drained", ov0, 0);
    chk("s0_cw_zero", ocw0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
